// File: rtl/ps2_tx_multi.sv
// ps2_tx_multi: bank of N_CH PS/2 device-side transmitters, each with a byte FIFO and host-inhibit abort
module ps2_tx_multi #(
    parameter int N_CH      = 2,
    parameter int CH_BITS   = 1,
    parameter int FIFO_BITS = 3
) (
    input  logic                          clk_sys,
    input  logic                          reset_n,
    input  logic                          ps2_clk,
    input  logic                          wr,
    input  logic [CH_BITS-1:0]            wr_ch,
    input  logic [7:0]                    wr_data,
    input  logic [N_CH-1:0]               clr_ovf,
    input  logic [N_CH-1:0]               ps2_inhibit,
    output logic [N_CH-1:0]               ps2_clk_out,
    output logic [N_CH-1:0]               ps2_dat_out,
    output logic [N_CH-1:0]               fifo_full,
    output logic [N_CH-1:0]               fifo_ovf,
    output logic [N_CH*(FIFO_BITS+1)-1:0] fifo_level
);
    localparam int DEPTH = 1 << FIFO_BITS;
    typedef enum logic [3:0] {IDLE, BIT0, BIT1, BIT2, BIT3, BIT4, BIT5, BIT6, BIT7, PARITY, STOP, DONE} state_t;
    logic clk_q;
    logic tick;
    always_ff @(posedge clk_sys or negedge reset_n)
        if (!reset_n) clk_q <= 1'b0;
        else clk_q <= ps2_clk;
    assign tick = ps2_clk & ~clk_q;
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [7:0]           mem [DEPTH];
        logic [FIFO_BITS-1:0] wptr;
        logic [FIFO_BITS-1:0] rptr;
        logic [FIFO_BITS:0]   level;
        logic [7:0]           shift;
        logic                 parity;
        logic                 dat;
        logic                 ovf;
        logic                 hit;
        logic                 push;
        logic                 pop;
        state_t               state;
        // level never exceeds DEPTH, so its MSB alone means full
        assign hit  = wr && wr_ch == CH_BITS'(c);
        assign push = hit && !level[FIFO_BITS];
        assign pop  = tick && state == DONE;
        always_ff @(posedge clk_sys)
            if (push) mem[wptr] <= wr_data;
        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                wptr   <= '0;
                rptr   <= '0;
                level  <= '0;
                shift  <= '0;
                parity <= 1'b0;
                dat    <= 1'b1;
                ovf    <= 1'b0;
                state  <= IDLE;
            end else begin
                if (push) wptr <= wptr + FIFO_BITS'(1);
                if (pop) rptr <= rptr + FIFO_BITS'(1);
                level <= level + {{FIFO_BITS{1'b0}}, push} - {{FIFO_BITS{1'b0}}, pop};
                ovf   <= (hit && level[FIFO_BITS]) | (ovf & ~clr_ovf[c]);
                // abort leaves the head byte queued so it restarts from the start bit
                if (ps2_inhibit[c] && state != IDLE && state != DONE) begin
                    state <= IDLE;
                    dat   <= 1'b1;
                end else if (tick) begin
                    case (state)
                        IDLE: if (|level && !ps2_inhibit[c]) begin
                            shift  <= mem[rptr];
                            parity <= 1'b1;
                            dat    <= 1'b0;
                            state  <= BIT0;
                        end
                        PARITY: begin
                            dat   <= parity;
                            state <= STOP;
                        end
                        STOP: begin
                            dat   <= 1'b1;
                            state <= DONE;
                        end
                        DONE: state <= IDLE;
                        default: begin
                            dat    <= shift[0];
                            shift  <= {1'b0, shift[7:1]};
                            parity <= parity ^ shift[0];
                            state  <= state_t'(state + 4'd1);
                        end
                    endcase
                end
            end
        end
        assign ps2_clk_out[c] = ps2_clk | (state == IDLE);
        assign ps2_dat_out[c] = dat;
        assign fifo_full[c]   = level[FIFO_BITS];
        assign fifo_ovf[c]    = ovf;
        assign fifo_level[c*(FIFO_BITS+1) +: FIFO_BITS+1] = level;
    end
endmodule

// File: tb/tb_ps2_tx_multi.sv
// tb_ps2_tx_multi: directed table-driven bench for the two-channel default ps2_tx_multi
module tb_ps2_tx_multi;
    logic       clk_sys = 1'b0;
    logic       reset_n = 1'b1;
    logic       ps2_clk = 1'b0;
    logic       wr = 1'b0;
    logic [0:0] wr_ch = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [1:0] clr_ovf = 2'b00;
    logic [1:0] ps2_inhibit = 2'b00;
    logic [1:0] ps2_clk_out;
    logic [1:0] ps2_dat_out;
    logic [1:0] fifo_full;
    logic [1:0] fifo_ovf;
    logic [7:0] fifo_level;
    int checks = 0;
    int errors = 0;
    typedef struct {logic ch; logic [7:0] b; logic par;} vec_t;
    vec_t tbl [9];
    logic [7:0] pv;

    ps2_tx_multi dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ps2_clk(ps2_clk), .wr(wr), .wr_ch(wr_ch),
        .wr_data(wr_data), .clr_ovf(clr_ovf), .ps2_inhibit(ps2_inhibit), .ps2_clk_out(ps2_clk_out),
        .ps2_dat_out(ps2_dat_out), .fifo_full(fifo_full), .fifo_ovf(fifo_ovf), .fifo_level(fifo_level)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", n, a, e);
        end
    endtask

    function automatic logic [3:0] lvl(input int ch);
        return fifo_level[ch*4 +: 4];
    endfunction

    function automatic logic [10:0] fr(input logic [7:0] b, input logic p);
        return {1'b1, p, b, 1'b0};
    endfunction

    task automatic tick(input logic do_wr = 1'b0, input logic ch = 1'b0, input logic [7:0] d = 8'h00);
        @(negedge clk_sys);
        ps2_clk = 1'b1; wr = do_wr; wr_ch = ch; wr_data = d;
        @(negedge clk_sys);
        wr = 1'b0;
        @(negedge clk_sys);
        ps2_clk = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic write(input logic ch, input logic [7:0] d);
        @(negedge clk_sys);
        wr = 1'b1; wr_ch = ch; wr_data = d;
        @(negedge clk_sys);
        wr = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic clear_ovf(input logic [1:0] m);
        @(negedge clk_sys);
        clr_ovf = m;
        @(negedge clk_sys);
        clr_ovf = 2'b00;
    endtask

    // 12 ticks; the last one can carry a coincident write
    task automatic run_frames(input logic [10:0] f0, input logic [10:0] f1, input logic [1:0] act,
                              input logic do_wr = 1'b0, input logic wch = 1'b0, input logic [7:0] wd = 8'h00);
        for (int k = 0; k < 12; k++) begin
            if (k == 11) tick(do_wr, wch, wd);
            else tick();
            for (int c = 0; c < 2; c++) begin
                logic [10:0] f;
                f = (c == 1) ? f1 : f0;
                chk($sformatf("dat ch%0d tick%0d", c, k + 1), 32'(ps2_dat_out[c]),
                    32'((act[c] && k < 11) ? f[k] : 1'b1));
                chk($sformatf("clk_out ch%0d tick%0d", c, k + 1), 32'(ps2_clk_out[c]),
                    32'((act[c] && k < 11) ? 1'b0 : 1'b1));
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        tbl = '{'{1'b0, 8'hAA, 1'b1}, '{1'b0, 8'h01, 1'b0}, '{1'b1, 8'h00, 1'b1},
                '{1'b1, 8'hFF, 1'b1}, '{1'b0, 8'h34, 1'b0}, '{1'b1, 8'h80, 1'b0},
                '{1'b0, 8'h7F, 1'b0}, '{1'b1, 8'hC3, 1'b1}, '{1'b0, 8'hE0, 1'b0}};
        pv = 8'b10010110;
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk_sys);
        chk("reset dat", 32'(ps2_dat_out), 32'h3);
        chk("reset clk_out", 32'(ps2_clk_out), 32'h3);
        chk("reset level", 32'(fifo_level), 32'h0);
        chk("reset full", 32'(fifo_full), 32'h0);
        chk("reset ovf", 32'(fifo_ovf), 32'h0);
        reset_n = 1'b1;
        tick();
        tick();
        chk("idle clk_out", 32'(ps2_clk_out), 32'h3);
        chk("idle dat", 32'(ps2_dat_out), 32'h3);
        for (int i = 0; i < 9; i++) begin
            write(tbl[i].ch, tbl[i].b);
            chk($sformatf("vec%0d level after write", i), 32'(lvl(tbl[i].ch)), 32'd1);
            run_frames(fr(tbl[i].b, tbl[i].par), fr(tbl[i].b, tbl[i].par), tbl[i].ch ? 2'b10 : 2'b01);
            chk($sformatf("vec%0d level after pop", i), 32'(lvl(tbl[i].ch)), 32'd0);
        end
        for (int i = 0; i < 8; i++) begin
            write(1'b1, 8'h10 + 8'(i));
            if (i == 6) chk("full at 7", 32'(fifo_full), 32'h0);
        end
        chk("full at 8", 32'(fifo_full), 32'h2);
        chk("level at 8", 32'(lvl(1)), 32'd8);
        chk("ovf before drop", 32'(fifo_ovf), 32'h0);
        write(1'b1, 8'hEE);
        chk("ovf after drop", 32'(fifo_ovf), 32'h2);
        chk("level after drop", 32'(lvl(1)), 32'd8);
        clear_ovf(2'b10);
        chk("ovf cleared", 32'(fifo_ovf), 32'h0);
        run_frames(11'h0, fr(8'h10, pv[0]), 2'b10, 1'b1, 1'b1, 8'h99);
        chk("full+pop level", 32'(lvl(1)), 32'd7);
        chk("full+pop ovf", 32'(fifo_ovf), 32'h2);
        chk("full+pop full", 32'(fifo_full), 32'h0);
        clear_ovf(2'b10);
        run_frames(11'h0, fr(8'h11, pv[1]), 2'b10, 1'b1, 1'b1, 8'h55);
        chk("push+pop level", 32'(lvl(1)), 32'd7);
        chk("push+pop ovf", 32'(fifo_ovf), 32'h0);
        for (int j = 2; j < 8; j++) run_frames(11'h0, fr(8'h10 + 8'(j), pv[j]), 2'b10);
        run_frames(11'h0, fr(8'h55, 1'b1), 2'b10);
        chk("drained level", 32'(lvl(1)), 32'd0);
        tick();
        chk("9th never sent", 32'(ps2_dat_out), 32'h3);
        write(1'b0, 8'h5C);
        tick();
        tick();
        tick();
        chk("pre-inhibit dat", 32'(ps2_dat_out[0]), 32'h0);
        @(negedge clk_sys);
        ps2_inhibit = 2'b01;
        @(negedge clk_sys);
        chk("inhibit dat", 32'(ps2_dat_out[0]), 32'h1);
        chk("inhibit clk_out", 32'(ps2_clk_out[0]), 32'h1);
        chk("inhibit level", 32'(lvl(0)), 32'd1);
        tick();
        chk("inhibit no start", 32'(ps2_dat_out[0]), 32'h1);
        ps2_inhibit = 2'b00;
        run_frames(fr(8'h5C, 1'b1), 11'h0, 2'b01);
        chk("resent level", 32'(lvl(0)), 32'd0);
        write(1'b0, 8'h12);
        write(1'b1, 8'h34);
        run_frames(fr(8'h12, 1'b1), fr(8'h34, 1'b0), 2'b11);
        chk("lockstep level", 32'(fifo_level), 32'h0);
        write(1'b0, 8'hAA);
        tick();
        chk("mid start bit", 32'(ps2_dat_out[0]), 32'h0);
        #2 reset_n = 1'b0;
        #1;
        chk("mid reset dat", 32'(ps2_dat_out), 32'h3);
        chk("mid reset clk_out", 32'(ps2_clk_out), 32'h3);
        chk("mid reset level", 32'(fifo_level), 32'h0);
        @(negedge clk_sys);
        reset_n = 1'b1;
        tick();
        chk("after reset idle", 32'(ps2_dat_out), 32'h3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
